// File: rtl/alu_result_serializer.sv
// alu_result_serializer
// Buffers {carry, result} words from the ALU stage in a small FIFO.
// Each word goes out as a two-byte frame on an 8-bit valid/ready bus.
// The outputs come straight from registers, and the frame FSM refills its hold
// register from the FIFO head. This lets frames run back-to-back with no idle gap.
module alu_result_serializer #(
  parameter int DEPTH    = 2,  // FIFO entries, power of two, >= 2
  parameter int HI_FIRST = 0   // 0: low byte first, 1: high byte first
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         res_valid,
  output logic                         res_ready,
  input  logic [9:0]                   res_q,
  input  logic                         carry_q,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   out_data,
  output logic                         out_last,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEND0 = 2'd1;
  localparam logic [1:0] S_SEND1 = 2'd2;

  // FIFO storage and bookkeeping
  logic [10:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Frame engine state
  logic [1:0]    r_state;
  logic [10:0]   r_hold;
  logic [2:0]    r_seq;
  logic          r_out_valid;
  logic [7:0]    r_out_data;
  logic          r_out_last;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_frame_done;
  logic          w_pop;
  logic [2:0]    w_seq_next;
  logic [10:0]   w_head;
  logic [7:0]    w_head_lo;
  logic [7:0]    w_head_hi;
  logic [7:0]    w_head_byte0;
  logic [7:0]    w_hold_lo;
  logic [7:0]    w_hold_hi;
  logic [7:0]    w_hold_byte1;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // There is no bypass. A full FIFO refuses input even when it pops in the same cycle.
  assign res_ready = !w_full && !flush;
  assign w_push    = res_valid && res_ready;

  // A frame completes when its second byte is taken. Only then is the next entry pulled.
  assign w_frame_done = (r_state == S_SEND1) && out_ready;
  assign w_pop        = !flush && !w_empty &&
                        ((r_state == S_IDLE) || w_frame_done);

  // A back-to-back frame must carry the sequence number after the increment.
  assign w_seq_next = w_frame_done ? (r_seq + 3'd1) : r_seq;

  assign w_head    = r_mem[r_rd_ptr];
  assign w_head_lo = w_head[7:0];
  assign w_head_hi = {w_head[10], w_seq_next, 2'b00, w_head[9:8]};
  assign w_hold_lo = r_hold[7:0];
  assign w_hold_hi = {r_hold[10], r_seq, 2'b00, r_hold[9:8]};

  // Select the byte order once, here, so the FSM stays independent of it.
  generate
    if (HI_FIRST != 0) begin : g_hi_first
      assign w_head_byte0 = w_head_hi;
      assign w_hold_byte1 = w_hold_lo;
    end else begin : g_lo_first
      assign w_head_byte0 = w_head_lo;
      assign w_hold_byte1 = w_hold_hi;
    end
  endgenerate

  // FIFO storage write. It has no reset, so it can map onto plain memory.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {carry_q, res_q};
    end
  end

  // FIFO pointers and occupancy. Flush empties the FIFO without touching storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame sequence counter. It advances only on a completed frame and survives flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq <= 3'd0;
    end else if (!flush && w_frame_done) begin
      r_seq <= w_seq_next;
    end
  end

  // Frame FSM with registered outputs. Flush drops any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
      r_out_last  <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_hold      <= w_head;
            r_state     <= S_SEND0;
            r_out_valid <= 1'b1;
            r_out_data  <= w_head_byte0;
            r_out_last  <= 1'b0;
          end
        end
        S_SEND0: begin
          if (out_ready) begin
            r_state    <= S_SEND1;
            r_out_data <= w_hold_byte1;
            r_out_last <= 1'b1;
          end
        end
        S_SEND1: begin
          if (out_ready) begin
            if (w_pop) begin
              r_hold      <= w_head;
              r_state     <= S_SEND0;
              r_out_valid <= 1'b1;
              r_out_data  <= w_head_byte0;
              r_out_last  <= 1'b0;
            end else begin
              r_state     <= S_IDLE;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_last   = r_out_last;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Testbench for alu_result_serializer.
// Two instances share all inputs: HI_FIRST=0 and HI_FIRST=1.
// The stimulus side drives handshakes. A negedge monitor keeps a per-instance model.
// The model holds a queue of accepted words, a frame sequence number and the current
// byte position. The monitor checks every transferred byte against that model.
module tb_alu_result_serializer;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       res_valid;
  logic [9:0] res_q;
  logic       carry_q;
  logic       out_ready;

  logic       res_ready_w  [2];
  logic       out_valid_w  [2];
  logic [7:0] out_data_w   [2];
  logic       out_last_w   [2];
  logic [1:0] fifo_count_w [2];

  int n_pass;
  int n_total;

  // Reference model state, one set per instance
  logic [10:0] pend_q [2][$];
  int          mseq   [2];
  int          mphase [2];
  logic        prev_stall [2];
  logic [7:0]  prev_data  [2];
  logic        prev_last  [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      alu_result_serializer #(.DEPTH(2), .HI_FIRST(gi)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .res_valid  (res_valid),
        .res_ready  (res_ready_w[gi]),
        .res_q      (res_q),
        .carry_q    (carry_q),
        .out_valid  (out_valid_w[gi]),
        .out_ready  (out_ready),
        .out_data   (out_data_w[gi]),
        .out_last   (out_last_w[gi]),
        .fifo_count (fifo_count_w[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
  endtask

  // Frame byte as defined by the output format, from a stored {carry,res} word
  function automatic logic [7:0] exp_byte(input logic [10:0] e, input int seq,
                                          input int hi_first, input int phase);
    logic [7:0] lo;
    logic [7:0] hi;
    lo = e[7:0];
    hi = {e[10], 3'(seq), 2'b00, e[9:8]};
    if ((phase == 0) == (hi_first == 0)) return lo;
    return hi;
  endfunction

  // Scoreboard monitor: pushes accepted words, then pops and compares each byte transfer
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        pend_q[k].delete();
        mseq[k]       = 0;
        mphase[k]     = 0;
        prev_stall[k] = 1'b0;
      end else begin
        if (prev_stall[k]) begin
          check("stall_valid", 32'(out_valid_w[k]), 32'd1);
          check("stall_data",  32'(out_data_w[k]),  32'(prev_data[k]));
          check("stall_last",  32'(out_last_w[k]),  32'(prev_last[k]));
        end
        if (flush) begin
          check("flush_res_ready", 32'(res_ready_w[k]), 32'd0);
          pend_q[k].delete();
          mphase[k]     = 0;
          prev_stall[k] = 1'b0;
        end else begin
          if (out_valid_w[k] && out_ready) begin
            if (pend_q[k].size() == 0) begin
              check("unexpected_byte", 32'(out_data_w[k]), 32'hFFFF_FFFF);
            end else begin
              check("byte_data", 32'(out_data_w[k]),
                    32'(exp_byte(pend_q[k][0], mseq[k], k, mphase[k])));
              check("byte_last", 32'(out_last_w[k]), 32'(mphase[k] == 1));
              if (mphase[k] == 1) begin
                void'(pend_q[k].pop_front());
                mseq[k]   = (mseq[k] + 1) % 8;
                mphase[k] = 0;
              end else begin
                mphase[k] = 1;
              end
            end
          end
          if (res_valid && res_ready_w[k]) pend_q[k].push_back({carry_q, res_q});
          prev_stall[k] = out_valid_w[k] && !out_ready;
          prev_data[k]  = out_data_w[k];
          prev_last[k]  = out_last_w[k];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word and hold it until it is accepted, or until the bound expires
  task automatic send(input logic [9:0] r, input logic c);
    int  n;
    bit  acc;
    n   = 0;
    acc = 1'b0;
    res_q     = r;
    carry_q   = c;
    res_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = res_ready_w[0];
      tick();
      n++;
    end
    res_valid = 1'b0;
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid_w[0] && n < 50) begin
      tick();
      n++;
    end
    if (!out_valid_w[0]) check("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((pend_q[0].size() != 0 || pend_q[1].size() != 0) && n < 200) begin
      tick();
      n++;
    end
    check("drain_q0", 32'(pend_q[0].size()), 32'd0);
    check("drain_q1", 32'(pend_q[1].size()), 32'd0);
  endtask

  logic [7:0] e_byte;

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    res_valid = 1'b0;
    res_q     = '0;
    carry_q   = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_out_valid",  32'(out_valid_w[0]),  32'd0);
    check("rst_out_data",   32'(out_data_w[0]),   32'h00);
    check("rst_out_last",   32'(out_last_w[0]),   32'd0);
    check("rst_fifo_count", 32'(fifo_count_w[0]), 32'd0);
    check("rst_res_ready",  32'(res_ready_w[0]),  32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic frame and latency
    out_ready = 1'b1;
    send(10'h2A5, 1'b1);
    check("lat_valid_early", 32'(out_valid_w[0]),  32'd0);
    check("lat_count",       32'(fifo_count_w[0]), 32'd1);
    tick();
    check("lat_valid",  32'(out_valid_w[0]), 32'd1);
    check("lat_byte0",  32'(out_data_w[0]),  32'hA5);
    check("lat_last0",  32'(out_last_w[0]),  32'd0);
    check("lat_hi0",    32'(out_data_w[1]),  32'h82);
    drain();

    // Backpressure: hold register plus two FIFO entries
    out_ready = 1'b0;
    send(10'h011, 1'b0);
    send(10'h122, 1'b1);
    send(10'h233, 1'b0);
    res_q     = 10'h344;
    carry_q   = 1'b1;
    res_valid = 1'b1;
    tick();
    tick();
    check("bp_res_ready", 32'(res_ready_w[0]),  32'd0);
    check("bp_count",     32'(fifo_count_w[0]), 32'd2);
    check("bp_byte0",     32'(out_data_w[0]),   32'h11);
    out_ready = 1'b1;
    send(10'h344, 1'b1);
    drain();

    // Nine identical frames exercise the sequence wrap
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) send(10'h3FF, 1'b0);
    drain();

    // Stall during the second byte
    out_ready = 1'b0;
    send(10'h1C3, 1'b1);
    wait_valid();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    e_byte = {1'b1, 3'(mseq[0]), 2'b00, 2'b01};
    for (int i = 0; i < 5; i++) begin
      check("stall1_data", 32'(out_data_w[0]), 32'(e_byte));
      check("stall1_last", 32'(out_last_w[0]), 32'd1);
      tick();
    end
    drain();

    // Flush with the FIFO full and the hold register loaded
    out_ready = 1'b0;
    send(10'h0AA, 1'b0);
    send(10'h0BB, 1'b1);
    send(10'h0CC, 1'b0);
    tick();
    check("pre_flush_count", 32'(fifo_count_w[0]), 32'd2);
    check("pre_flush_valid", 32'(out_valid_w[0]),  32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_count", 32'(fifo_count_w[0]), 32'd0);
    check("flush_valid", 32'(out_valid_w[0]),  32'd0);
    check("flush_last",  32'(out_last_w[0]),   32'd0);
    out_ready = 1'b1;
    send(10'h0F0, 1'b1);
    drain();

    // Random traffic with random backpressure and occasional flush
    res_valid = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit acc;
      @(negedge clk);
      acc = res_valid && res_ready_w[0];
      tick();
      if (acc) res_valid = 1'b0;
      flush     = (cyc < 400) && ($urandom_range(0, 39) == 0);
      out_ready = flush ? 1'b0 : ((cyc >= 400) || ($urandom_range(0, 3) != 0));
      if (!res_valid && cyc < 400 && $urandom_range(0, 1) == 1) begin
        res_q     = 10'($urandom);
        carry_q   = 1'($urandom);
        res_valid = 1'b1;
      end
      if (cyc >= 400 && !res_valid) break;
    end
    flush = 1'b0;
    drain();

    // HI_FIRST instance, then an asynchronous reset in the middle of the second byte
    out_ready = 1'b0;
    send(10'h155, 1'b0);
    wait_valid();
    e_byte = {1'b0, 3'(mseq[1]), 2'b00, 2'b01};
    check("hf_byte0", 32'(out_data_w[1]), 32'(e_byte));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hf_byte1", 32'(out_data_w[1]), 32'h55);
    check("hf_last1", 32'(out_last_w[1]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid0", 32'(out_valid_w[0]),  32'd0);
    check("arst_valid1", 32'(out_valid_w[1]),  32'd0);
    check("arst_last",   32'(out_last_w[1]),   32'd0);
    check("arst_data",   32'(out_data_w[1]),   32'h00);
    check("arst_count",  32'(fifo_count_w[0]), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    send(10'h2A5, 1'b1);
    tick();
    check("post_rst_byte0", 32'(out_data_w[0]), 32'hA5);
    check("post_rst_hi",    32'(out_data_w[1]), 32'h82);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
